// File: rtl/lut_config_loader_if.sv
// Serial configuration bit stream with valid/ready flow control.
// The master is the bitstream source; the slave is the loader.
interface lut_config_loader_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (output bit_in, output bit_valid, input  bit_ready);
  modport slave  (input  bit_in, input  bit_valid, output bit_ready);
endinterface

// File: rtl/lut_config_loader.sv
// Assembles a serial configuration bitstream into MEM_SIZE-bit frames and
// commits each frame to the next LUT of the bank with a one-cycle cen strobe.
module lut_config_loader #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS,
  parameter int NUM_LUTS  = 4
) (
  input  logic                 cclk,
  input  logic                 crst_n,
  input  logic                 start,
  lut_config_loader_if.slave   bs,
  output logic [MEM_SIZE-1:0]  config_out,
  output logic [NUM_LUTS-1:0]  cen,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam int CNT_W = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MEM_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_LUT = IDX_W'(NUM_LUTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [IDX_W-1:0]    r_lut_idx;
  logic [MEM_SIZE-1:0] r_shift;
  logic                w_accept;
  logic                w_last_bit;
  logic                w_last_lut;

  assign w_accept   = (r_state == S_SHIFT) && bs.bit_valid;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_last_lut = (r_lut_idx == LAST_LUT);
  assign config_out = r_shift;

  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Handshake and strobes decode from r_state alone, so no input reaches them.
  always_comb begin
    w_next       = r_state;
    bs.bit_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    cen          = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        bs.bit_ready = 1'b1;
        busy         = 1'b1;
        if (w_accept && w_last_bit) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_LUTS; i++) cen[i] = (r_lut_idx == IDX_W'(i));
        w_next = w_last_lut ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      r_bit_cnt <= '0;
      r_lut_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bit_cnt <= '0;
            r_lut_idx <= '0;
          end
        end
        S_SHIFT: begin
          if (w_accept) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        S_COMMIT: begin
          if (!w_last_lut) begin
            r_lut_idx <= r_lut_idx + 1'b1;
            r_bit_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // LSB-first stream: shifting right with the new bit at the MSB leaves
  // the first received bit in config_out[0] once the frame is complete.
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n)       r_shift <= '0;
    else if (w_accept) r_shift <= {bs.bit_in, r_shift[MEM_SIZE-1:1]};
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench: a 4-LUT loader and a 1-LUT loader driven by directed
// frames, with behavioural SRAM models capturing config_out on cen.
module tb_lut_config_loader;

  typedef struct {
    logic [3:0]  cen;
    logic [15:0] word;
  } exp_t;

  logic        cclk   = 1'b0;
  logic        crst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        tb_bit = 1'b0;
  logic        tb_valid = 1'b0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          gbit   = 0;

  logic [15:0] cfg0;
  logic [3:0]  cen0;
  logic        busy0, done0;
  logic [15:0] cfg1;
  logic [0:0]  cen1;
  logic        busy1, done1;

  logic [15:0] mem0 [4];
  logic [15:0] mem1;
  exp_t        q0[$];
  logic [15:0] q1[$];
  exp_t        e0;
  logic [15:0] e1;

  lut_config_loader_if bs0 ();
  lut_config_loader_if bs1 ();
  assign bs0.bit_in    = tb_bit;
  assign bs0.bit_valid = tb_valid;
  assign bs1.bit_in    = tb_bit;
  assign bs1.bit_valid = tb_valid;

  lut_config_loader #(.ADDR_BITS(4), .MEM_SIZE(16), .NUM_LUTS(4)) u_dut0 (
    .cclk(cclk), .crst_n(crst_n), .start(start0), .bs(bs0),
    .config_out(cfg0), .cen(cen0), .busy(busy0), .done(done0)
  );

  lut_config_loader #(.ADDR_BITS(4), .MEM_SIZE(16), .NUM_LUTS(1)) u_dut1 (
    .cclk(cclk), .crst_n(crst_n), .start(start1), .bs(bs1),
    .config_out(cfg1), .cen(cen1), .busy(busy1), .done(done1)
  );

  initial forever begin
    #5 cclk = 1'b1;
    cyc++;
    #5 cclk = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural bit_writable_sram frame capture.
  initial forever begin
    @(posedge cclk);
    for (int i = 0; i < 4; i++) if (cen0[i] === 1'b1) mem0[i] <= cfg0;
    if (cen1[0] === 1'b1) mem1 <= cfg1;
  end

  // Monitor: pops the scoreboard whenever a cen strobe is presented.
  initial forever begin
    @(negedge cclk);
    if (cen0 !== 4'b0) begin
      if (q0.size() == 0) chk("unexpected_cen0", 32'(cen0), 32'h0);
      else begin
        e0 = q0.pop_front();
        chk("cen0_onehot", 32'(cen0), 32'(e0.cen));
        chk("cfg0_word", 32'(cfg0), 32'(e0.word));
        chk("ready0_in_commit", 32'(bs0.bit_ready), 32'h0);
      end
    end
    if (done0 === 1'b1) chk("ready0_in_done", 32'(bs0.bit_ready), 32'h0);
    if (cen1 !== 1'b0) begin
      if (q1.size() == 0) chk("unexpected_cen1", 32'(cen1), 32'h0);
      else begin
        e1 = q1.pop_front();
        chk("cfg1_word", 32'(cfg1), 32'(e1));
        chk("ready1_in_commit", 32'(bs1.bit_ready), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic send_bit(input bit sel, input logic b, output bit ok);
    bit rdy;
    tb_bit   = b;
    tb_valid = 1'b1;
    ok       = 1'b0;
    for (int g = 0; g < 50; g++) begin
      @(negedge cclk);
      rdy = sel ? bs1.bit_ready : bs0.bit_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_word(input bit sel, input logic [15:0] w, input int nbits,
                           input bit stall, input int start_at);
    bit ok;
    for (int k = 0; k < nbits; k++) begin
      if (k == start_at) start0 = 1'b1;
      send_bit(sel, w[k], ok);
      start0 = 1'b0;
      if (!ok) chk("bit_accept_timeout", 32'(ok), 32'h1);
      gbit++;
      if (stall && (gbit % 5 == 0)) begin
        tb_valid = 1'b0;
        repeat (3) step();
      end
    end
  endtask

  task automatic start_seq(input bit sel, output int t0);
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    t0     = cyc;
  endtask

  task automatic wait_done(input bit sel, input int t0, input int exp_cycles);
    bit seen = 1'b0;
    int d    = 0;
    for (int g = 0; g < 400; g++) begin
      @(negedge cclk);
      if ((sel ? done1 : done0) === 1'b1) begin
        seen = 1'b1;
        d    = cyc - t0;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'h1);
    chk("done_latency", 32'(d), 32'(exp_cycles));
    @(negedge cclk);
    chk("done_one_cycle", 32'(sel ? done1 : done0), 32'h0);
    chk("idle_after_done", 32'(sel ? busy1 : busy0), 32'h0);
  endtask

  task automatic run_load(input logic [15:0] ws [4], input bit stall,
                          input int ign_frame, input int exp_cycles);
    int t0;
    gbit = 0;
    for (int i = 0; i < 4; i++) q0.push_back(exp_t'{cen: 4'(1 << i), word: ws[i]});
    start_seq(1'b0, t0);
    for (int i = 0; i < 4; i++) send_word(1'b0, ws[i], 16, stall, (i == ign_frame) ? 3 : -1);
    tb_valid = 1'b0;
    wait_done(1'b0, t0, exp_cycles);
    for (int i = 0; i < 4; i++) chk("sram_readback", 32'(mem0[i]), 32'(ws[i]));
  endtask

  initial begin
    int t0;
    logic [15:0] basic [4];
    logic [15:0] rep   [4];
    basic = '{16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF};
    rep   = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};

    repeat (3) step();
    chk("rst_cfg0", 32'(cfg0), 32'h0);
    chk("rst_cen0", 32'(cen0), 32'h0);
    chk("rst_ready0", 32'(bs0.bit_ready), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_done0", 32'(done0), 32'h0);
    chk("rst_cen1", 32'(cen1), 32'h0);
    crst_n = 1'b1;
    step();

    // 4 frames x (16 shift + 1 commit) = 68; stalls add 12 x 3 = 36 more.
    run_load(basic, 1'b0, -1, 68);
    run_load(basic, 1'b1, -1, 104);
    run_load(basic, 1'b0, 1, 68);

    start_seq(1'b0, t0);
    gbit = 0;
    send_word(1'b0, 16'hBEEF, 7, 1'b0, -1);
    crst_n = 1'b0;
    #1;
    chk("midrst_cen0", 32'(cen0), 32'h0);
    chk("midrst_busy0", 32'(busy0), 32'h0);
    chk("midrst_ready0", 32'(bs0.bit_ready), 32'h0);
    chk("midrst_cfg0", 32'(cfg0), 32'h0);
    chk("midrst_done0", 32'(done0), 32'h0);
    tb_valid = 1'b0;
    repeat (2) step();
    crst_n = 1'b1;
    step();
    run_load(rep, 1'b0, -1, 68);

    q1.push_back(16'h5A5A);
    start_seq(1'b1, t0);
    send_word(1'b1, 16'h5A5A, 16, 1'b0, -1);
    tb_valid = 1'b0;
    wait_done(1'b1, t0, 17);
    chk("sram1_readback", 32'(mem1), 32'h5A5A);

    repeat (2) step();
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
